// File: rtl/keyexpansion_core.sv
// AES-128 key expansion: one 128-bit round key per clock, all 11 round keys on out.
// Optional busy output is enabled by defining KEYEXPANSION_BUSY_EN.

module keyexpansion_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = SBOX[a];
endmodule

module keyexpansion_core (
    input  logic          clk,
    input  logic          rst,
    input  logic [127:0]  key,
    input  logic          start,
    output logic          finish,
`ifdef KEYEXPANSION_BUSY_EN
    output logic          busy,
`endif
    output logic [1407:0] out
);
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t              state, state_nxt;
    logic [3:0]          rcnt;
    logic [0:10][127:0]  rk;
    logic [127:0]        last;
    logic [31:0]         rot, sub, temp;
    logic [7:0]          rcon;
    logic [127:0]        nxt;

    // Word schedule step for four consecutive words, chained off the previous round key.
    assign rot = {last[23:0], last[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        keyexpansion_sbox u_sbox (.a(rot[8*g +: 8]), .y(sub[8*g +: 8]));
    end

    always_comb begin
        rcon = 8'h00;
        case (rcnt)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign temp           = sub ^ {rcon, 24'h0};
    assign nxt[127:96]    = last[127:96] ^ temp;
    assign nxt[95:64]     = last[95:64]  ^ nxt[127:96];
    assign nxt[63:32]     = last[63:32]  ^ nxt[95:64];
    assign nxt[31:0]      = last[31:0]   ^ nxt[63:32];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = EXPAND;
            EXPAND:     if (rcnt == 4'd10) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcnt <= 4'd0;
            rk   <= '0;
            last <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        rk    <= '0;
                        rk[0] <= key;
                        last  <= key;
                        rcnt  <= 4'd1;
                    end
                end
                EXPAND: begin
                    rk[rcnt] <= nxt;
                    last     <= nxt;
                    if (rcnt != 4'd10) rcnt <= rcnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign finish = (state == DONE);
    assign out    = rk;
`ifdef KEYEXPANSION_BUSY_EN
    assign busy   = (state == EXPAND);
`endif
endmodule

// File: tb/tb_keyexpansion_core.sv
// Directed + random checks of keyexpansion_core against a GF(2^8)-arithmetic key schedule model.
module tb_keyexpansion_core;
    logic          clk = 1'b0;
    logic          rst;
    logic [127:0]  key;
    logic          start;
    logic          finish;
    logic [1407:0] out;
`ifdef KEYEXPANSION_BUSY_EN
    logic          busy;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    keyexpansion_core dut (
        .clk(clk), .rst(rst), .key(key), .start(start), .finish(finish),
`ifdef KEYEXPANSION_BUSY_EN
        .busy(busy),
`endif
        .out(out)
    );

    // Reference model: S-box from field inverse + affine map, Rcon by repeated doubling.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        if (x != 8'h00)
            for (int y = 1; y < 256; y++)
                if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [1407:0] ref_sched(input logic [127:0] k);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [1407:0] s;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) s[1407-32*i -: 32] = w[i];
        return s;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_sched(input string tag, input logic [1407:0] exp);
        for (int i = 0; i < 11; i++)
            chk($sformatf("%s_rk%0d", tag, i), out[1407-128*i -: 128], exp[1407-128*i -: 128]);
    endtask

    // Start pulse sampled at edge 1; optionally pulse start with k2 before edge inj.
    task automatic expand(input string tag, input logic [127:0] k, input int inj, input logic [127:0] k2);
        int bcnt = 0;
        @(negedge clk);
        key   = k;
        start = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            @(negedge clk);
`ifdef KEYEXPANSION_BUSY_EN
            if (busy === 1'b1) bcnt++;
`endif
            start = (e + 1 == inj);
            if (e + 1 == inj) key = k2;
            if (e == 1 || e == 10) chk({tag, "_finish_low"}, 128'(finish), 128'(1'b0));
            if (e == 11) chk({tag, "_finish_edge11"}, 128'(finish), 128'(1'b1));
        end
`ifdef KEYEXPANSION_BUSY_EN
        chk({tag, "_busy_cycles"}, 128'(bcnt), 128'(10));
        chk({tag, "_busy_done"}, 128'(busy), 128'(1'b0));
`endif
        start = 1'b0;
    endtask

    logic [1407:0] exp_s;
    logic [127:0]  rk_a, rk_b;

    initial begin
        rst   = 1'b0;
        start = 1'b1;
        key   = {$urandom, $urandom, $urandom, $urandom};

        // Held in reset with start high: nothing may be sampled.
        repeat (3) @(negedge clk);
        chk("rst_finish", 128'(finish), 128'(1'b0));
        chk("rst_out_zero", 128'(out === '0), 128'(1'b1));
        start = 1'b0;
        rst   = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", 128'(finish), 128'(1'b0));

        // FIPS-197 vector.
        rk_a = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
        expand("fips", rk_a, 0, '0);
        chk("fips_w4", 128'(out[1279:1248]), 128'(32'hA0FAFE17));
        chk("fips_rk10", out[127:0], 128'hD014F9A8C9EE2589E13F0CC8B6630CA6);
        chk_sched("fips", ref_sched(rk_a));

        // DONE holds out stable.
        exp_s = out;
        repeat (4) @(negedge clk);
        chk("done_hold_finish", 128'(finish), 128'(1'b1));
        chk("done_hold_out", 128'(out === exp_s), 128'(1'b1));

        // Restart from DONE with the all-zero key.
        @(negedge clk);
        key   = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_finish_drop", 128'(finish), 128'(1'b0));
        chk("restart_rk0", out[1407:1280], 128'h0);
        chk("restart_rk10_cleared", out[127:0], 128'h0);
        repeat (9) @(negedge clk);
        chk("restart_finish_edge10", 128'(finish), 128'(1'b0));
        @(negedge clk);
        chk("restart_finish_edge11", 128'(finish), 128'(1'b1));
        chk("zero_rk10", out[127:0], 128'hB4EF5BCB3E92E21123E951CF6F8F188E);
        chk_sched("zero", ref_sched('0));

        // ASCII key.
        rk_a = 128'h657870616E642033322D62797465206B;
        expand("ascii", rk_a, 0, '0);
        chk("ascii_rk0", out[1407:1280], rk_a);
        chk_sched("ascii", ref_sched(rk_a));

        // Start with a different key during EXPAND is ignored.
        rk_a = {$urandom, $urandom, $urandom, $urandom};
        rk_b = ~rk_a;
        expand("ign", rk_a, 4, rk_b);
        chk_sched("ign", ref_sched(rk_a));

        // Reset mid-EXPAND clears immediately; no finish without a new start.
        @(negedge clk);
        key   = {$urandom, $urandom, $urandom, $urandom};
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_finish", 128'(finish), 128'(1'b0));
        chk("abort_out_zero", 128'(out === '0), 128'(1'b1));
`ifdef KEYEXPANSION_BUSY_EN
        chk("abort_busy", 128'(busy), 128'(1'b0));
`endif
        @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        chk("abort_no_finish", 128'(finish), 128'(1'b0));
        chk("abort_out_stays_zero", 128'(out === '0), 128'(1'b1));

        // Random keys.
        for (int n = 0; n < 3; n++) begin
            rk_a = {$urandom, $urandom, $urandom, $urandom};
            expand($sformatf("rnd%0d", n), rk_a, 0, '0);
            chk_sched($sformatf("rnd%0d", n), ref_sched(rk_a));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/keyexpansion_core.md
KEYEXPANSION_CORE -- requirements
Module: keyexpansion

Interface
REQ-001 The module SHALL take its clock on clk: input, 1 bit, a single clock domain, rising-edge active.
REQ-002 The module SHALL take its reset on rst: input, 1 bit, asynchronous, active-low.
REQ-003 The module SHALL take the cipher key on key: input, 128 bits, AES-128 cipher key, byte 0 in key[127:120].
REQ-004 The module SHALL take start: input, 1 bit, request to expand key, sampled on the rising edge of clk.
REQ-005 The module SHALL drive finish: output, 1 bit, high when out holds a complete schedule.
REQ-006 The module SHALL drive out: output, 1408 bits, round keys 0..10; round key i occupies out[1407-128*i -: 128], w[4i] in its top 32 bits.

Function
REQ-007 The module SHALL implement the FIPS-197 AES-128 key expansion: w[0..3]=key; for i=4..43, temp=w[i-1]; when i%4==0, temp=SubWord(RotWord(temp)) XOR {Rcon[i/4],24'h0}; w[i]=w[i-4] XOR temp.
REQ-008 The module SHALL use Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36 (hex).
REQ-009 The module SHALL implement SubWord as four instances of the standard AES forward S-box, as combinational 256-entry lookups.
REQ-010 The module SHALL have the FSM states IDLE, EXPAND and DONE.
REQ-011 In IDLE or DONE, when start=1 at a clock edge, the module SHALL latch key into round key 0, clear round keys 1..10, set the round counter to 1, deassert finish and enter EXPAND.
REQ-012 In EXPAND, the module SHALL compute and store exactly one 128-bit round key (four words) per clock, for round counter r=1..10.
REQ-013 After storing round key 10, the module SHALL enter DONE and set finish=1 on the same edge; latency is 11 rising edges from the edge that samples start, counting the start edge as edge 1.
REQ-014 In EXPAND, the module SHALL ignore start; the key input is not used after it is latched.
REQ-015 In DONE, the module SHALL hold finish=1 and out stable until a new start or a reset.
REQ-016 If start and key change together in DONE, the module SHALL restart with the new key per REQ-011.

Reset
REQ-017 When rst=0, the module SHALL immediately force: state=IDLE, round counter=0, finish=0, out=0 (all 1408 bits), asynchronously to clk.
REQ-018 A reset asserted during EXPAND SHALL abort the expansion; after release, the module SHALL take no action until a new start.
REQ-019 The module SHALL not sample start while rst=0.

Configuration
REQ-020 When the macro KEYEXPANSION_BUSY_EN is defined, the module SHALL add an output busy (1 bit) that is high exactly while the state is EXPAND and resets to 0.
REQ-021 When KEYEXPANSION_BUSY_EN is not defined, the module SHALL not have a busy port; all other behaviour is identical.

Verification
REQ-022 Bench case, FIPS-197 vector: key=2B7E151628AED2A6ABF7158809CF4F3C, start pulsed for 1 cycle -> finish rises on the 11th edge; out[1279:1248]=A0FAFE17; out[127:0]=D014F9A8C9EE2589E13F0CC8B6630CA6.
REQ-023 Bench case, ASCII key: key="expand 32-byte k"=657870616E642033322D62797465206B -> out[1407:1280] equals that key; all 44 words match a software reference model; finish=1.
REQ-024 Bench case, reset: rst held at 0 -> finish=0 and out=0; rst=0 asserted mid-EXPAND (e.g., edge 5) -> immediate clear, no finish after release without a new start.
REQ-025 Bench case, start in EXPAND: start pulsed with a different key at edge 4 -> ignored; the schedule of the original key completes at edge 11.
REQ-026 Bench case, restart from DONE: start with key=000...0 -> finish drops, then rises 11 edges later; round key 10 = B4EF5BCB3E92E21123E951CF6F8F188E.
REQ-027 Bench case, with KEYEXPANSION_BUSY_EN defined: busy=1 for exactly 10 cycles per expansion and 0 otherwise.
